// File: rtl/voltmeter_pkg.sv
// Shared widths, FSM state encoding and the shift-add-3 step for the
// averaging voltmeter.
package voltmeter_pkg;

  localparam int SAMPLE_W = 12;
  localparam int MV_W     = 13;
  localparam int BCD_W    = 16;
  localparam int PROD_W   = 25;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    SCALE   = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } state_t;

  // One double-dabble step: correct every digit >= 5, then shift in the next binary bit.
  function automatic logic [BCD_W-1:0] bcd_shift(input logic [BCD_W-1:0] bcd,
                                                 input logic             bit_in);
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int d = 0; d < BCD_W / 4; d++) begin
      if (adj[d*4 +: 4] >= 4'd5) adj[d*4 +: 4] = adj[d*4 +: 4] + 4'd3;
    end
    return (adj << 1) | BCD_W'(bit_in);
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter, one bit per clock, MSB first.
// done is high in the cycle whose closing edge shifts in the final bit.
module bin2bcd_seq
  import voltmeter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MV_W-1:0]  bin,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  logic [MV_W-1:0]  shreg;
  logic [BCD_W-1:0] bcd_q;
  logic [3:0]       cnt;

  // start while idle loads the operand and already consumes its MSB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      bcd_q <= '0;
      cnt   <= '0;
    end else if (start && (cnt == 4'd0)) begin
      bcd_q <= bcd_shift('0, bin[MV_W-1]);
      shreg <= bin << 1;
      cnt   <= 4'(MV_W - 1);
    end else if (cnt != 4'd0) begin
      bcd_q <= bcd_shift(bcd_q, shreg[MV_W-1]);
      shreg <= shreg << 1;
      cnt   <= cnt - 4'd1;
    end
  end

  assign done = (cnt == 4'd1);
  assign bcd  = bcd_q;

endmodule

// File: rtl/voltage_averager_bcd.sv
// Averages 2^AVG_LOG2 ADC samples, scales to millivolts and presents the
// result in binary and as four BCD digits.
module voltage_averager_bcd
  import voltmeter_pkg::*;
#(
  parameter int AVG_LOG2 = 4,
  parameter int VREF_MV  = 5000
) (
  input  logic                MAX10_CLK1_50,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  output logic [MV_W-1:0]     mv_value,
  output logic [BCD_W-1:0]    bcd_value,
  output logic                result_valid,
  output logic                busy,
  output logic                overrun
);

  localparam int ACC_W = SAMPLE_W + AVG_LOG2;

  state_t              state, state_next;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    sum;
  logic [AVG_LOG2-1:0] cnt;
  logic [SAMPLE_W-1:0] avg;
  logic [MV_W-1:0]     mv;
  logic [MV_W-1:0]     mv_next;
  logic [PROD_W-1:0]   prod;
  logic                accept;
  logic                last_sample;
  logic                conv_start;
  logic                conv_done;
  logic [BCD_W-1:0]    conv_bcd;

  assign accept      = sample_valid && (state == ACCUM);
  assign last_sample = accept && (cnt == '1);
  assign sum         = acc + ACC_W'(sample_data);
  assign prod        = PROD_W'(avg) * PROD_W'(VREF_MV);
  assign mv_next     = MV_W'(prod >> SAMPLE_W);

  always_comb begin
    state_next = state;
    conv_start = 1'b0;
    busy       = 1'b1;
    case (state)
      ACCUM: begin
        busy = 1'b0;
        if (last_sample) state_next = SCALE;
      end
      SCALE:   state_next = CONVERT;
      CONVERT: begin
        conv_start = 1'b1;
        if (conv_done) state_next = DONE;
      end
      DONE:    state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  // The window-completing sample is folded into avg directly, never stored in acc.
  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
      avg <= '0;
      mv  <= '0;
    end else begin
      if (accept) begin
        if (last_sample) begin
          avg <= SAMPLE_W'(sum >> AVG_LOG2);
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
      if (state == SCALE) mv <= mv_next;
    end
  end

  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      mv_value     <= '0;
      bcd_value    <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      result_valid <= (state == DONE);
      overrun      <= sample_valid && (state != ACCUM);
      if (state == DONE) begin
        mv_value  <= mv;
        bcd_value <= conv_bcd;
      end
    end
  end

  bin2bcd_seq u_bin2bcd (
    .clk   (MAX10_CLK1_50),
    .rst   (reset),
    .start (conv_start),
    .bin   (mv),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

endmodule

// File: doc/voltage_averager_bcd.md
VOLTAGE_AVERAGER_BCD -- requirements
Module: voltage_averager_bcd

Interface
REQ-001 Parameter AVG_LOG2, default 4, meaning log2 of samples per averaging window (legal range 1..6).
REQ-002 Parameter VREF_MV, default 5000, meaning ADC full-scale in millivolts (legal range 1..8191).
REQ-003 MAX10_CLK1_50  input  1  meaning sole clock; all logic is on its rising edge.
REQ-004 reset  input  1  meaning asynchronous, active-high reset.
REQ-005 sample_valid  input  1  meaning ADC response strobe; one sample per high cycle.
REQ-006 sample_data  input  12  meaning unsigned ADC code, qualified by sample_valid.
REQ-007 mv_value  output  13  meaning last averaged voltage, in millivolts.
REQ-008 bcd_value  output  16  meaning mv_value as 4 BCD digits; [15:12] is thousands, [3:0] is units.
REQ-009 result_valid  output  1  meaning one-cycle pulse when mv_value/bcd_value update.
REQ-010 busy  output  1  meaning high whenever state is not ACCUM.
REQ-011 overrun  output  1  meaning one-cycle pulse when a sample is dropped.

Function
REQ-012 The FSM SHALL have the states ACCUM, SCALE, CONVERT and DONE.
REQ-013 In ACCUM, each sample_valid SHALL add sample_data to a (12+AVG_LOG2)-bit accumulator and increment a sample counter.
REQ-014 On the sample that completes 2^AVG_LOG2 samples, the block SHALL register avg = (acc + sample_data) >> AVG_LOG2, clear acc and the counter, and go to SCALE.
REQ-015 SCALE SHALL last 1 cycle, register mv = (avg * VREF_MV) >> 12 with a 25-bit product and truncation (no rounding), and go to CONVERT.
REQ-016 CONVERT SHALL run a shift-add-3 binary-to-BCD conversion of mv, one bit per cycle, for exactly 13 cycles, then go to DONE.
REQ-017 DONE SHALL last 1 cycle, load mv_value and bcd_value, pulse result_valid, and return to ACCUM.
REQ-018 Latency: result_valid SHALL be high in the cycle following the 16th rising edge after (and including) the edge that samples the window's final sample, i.e. 15 edges later.
REQ-019 mv_value and bcd_value SHALL hold their values between DONE updates.
REQ-020 A sample_valid while busy SHALL be discarded (not accumulated), and overrun SHALL pulse in the following cycle.
REQ-021 The accumulator SHALL never overflow: the maximum sum (4095 * 2^AVG_LOG2) fits in 12+AVG_LOG2 bits.
REQ-022 The maximum result (4095 * 5000 >> 12 = 4998) SHALL fit in 13 bits and 4 BCD digits.
REQ-023 Back-to-back sample_valid in ACCUM SHALL all be accepted; the window-completing sample SHALL be accepted even though busy rises on the next cycle.

Reset
REQ-024 On reset assertion, the block SHALL enter ACCUM and clear acc, the counter, avg, mv and the BCD shift register.
REQ-025 During reset, mv_value and bcd_value SHALL be 0; result_valid, busy and overrun SHALL be 0.
REQ-026 Reset in any state SHALL abandon the window or conversion in progress with no result_valid.
REQ-027 Samples after reset deassertion SHALL start a new window at count 0.

Structure
REQ-028 Package voltmeter_pkg SHALL hold SAMPLE_W=12, MV_W=13, BCD_W=16 and the FSM state enum.
REQ-029 The iterative BCD converter SHALL be sub-module bin2bcd_seq, with ports start, bin[12:0], done and bcd[15:0], driven by the CONVERT state.

Verification
REQ-030 16 samples of 4095, one every 50 cycles -> one result_valid; mv_value=4998, bcd_value=0x4998.
REQ-031 16 samples of 2048 -> mv_value=2500, bcd_value=0x2500; 16 samples of 0 -> mv_value=0, bcd_value=0x0000.
REQ-032 8 samples of 0 then 8 samples of 4095, back-to-back -> avg=2047, mv_value=2498, bcd_value=0x2498; result_valid exactly 15 edges after the final sample.
REQ-033 sample_valid held high continuously for 64 cycles -> after each window, 15 samples dropped with overrun pulses; every result equals the window average.
REQ-034 Reset asserted mid-CONVERT -> outputs zero, no result_valid; the next 16 samples of 1000 give mv_value=1220, bcd_value=0x1220.
